// File: rtl/hmc6502_pkg.sv
// Shared types for the hmc6502 memory-side blocks.
package hmc6502_pkg;

  typedef enum logic [1:0] {
    MBC_IDLE   = 2'd0,
    MBC_ACCESS = 2'd1,
    MBC_RESP   = 2'd2
  } mbc_state_t;

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Saturating wait-cycle counter; tc flags the cycle whose increment reaches MAX_WAIT.
module wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] TOP  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  // Saturates at MAX_WAIT so a stalled access can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding core-to-memory bus controller with wait-cycle timeout.
// Handshake: a request is taken on a posedge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no backpressure.
module mem_bus_ctrl
  import hmc6502_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output mbc_state_t            state_dbg
);

  mbc_state_t state, state_next;
  logic accept, done_ack, done_to;
  logic cnt_clr, cnt_en, cnt_tc;

  wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      MBC_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = MBC_ACCESS;
        end
      end
      MBC_ACCESS: begin
        // An ack in the same cycle as the timeout takes priority.
        if (mem_ack) begin
          done_ack   = 1'b1;
          state_next = MBC_RESP;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            done_to    = 1'b1;
            state_next = MBC_RESP;
          end
        end
      end
      MBC_RESP: state_next = MBC_IDLE;
      default:  state_next = MBC_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MBC_IDLE;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == MBC_IDLE);
      mem_en    <= (state_next == MBC_ACCESS);
      rsp_valid <= (state_next == MBC_RESP);
      if (accept) begin
        mem_we    <= req_write;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (done_ack) begin
        rsp_rdata <= mem_we ? '0 : mem_rdata;
        rsp_err   <= 1'b0;
      end else if (done_to) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized scoreboard bench for mem_bus_ctrl with a transaction-level memory model.
module tb_mem_bus_ctrl;
  import hmc6502_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  mbc_state_t    state_dbg;

  mem_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected responses: {err, rdata} plus the cycle at which they appear.
  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  // Memory-side model: what the controller must present and how the memory answers.
  logic          mq_we[$];
  logic [AW-1:0] mq_addr[$];
  logic [DW-1:0] mq_wdata[$];
  int            mq_delay[$];
  logic [DW-1:0] mq_rdata[$];

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int dly, input logic [DW-1:0] rd, input bit expect_rsp);
    int guard;
    int n;
    req_valid = 1'b1;
    req_write = we;
    req_addr  = a;
    req_wdata = wd;
    guard = 0;
    while (!req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    n = cyc + 1;
    mq_we.push_back(we);
    mq_addr.push_back(a);
    mq_wdata.push_back(wd);
    mq_delay.push_back(dly);
    mq_rdata.push_back(rd);
    if (expect_rsp) begin
      if (dly < MAX_WAIT) begin
        exp_q.push_back({1'b0, we ? {DW{1'b0}} : rd});
        exp_cyc_q.push_back(n + 1 + dly);
      end else begin
        exp_q.push_back({1'b1, {DW{1'b0}}});
        exp_cyc_q.push_back(n + MAX_WAIT);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  // ---------------- memory responder ----------------
  bit            m_active = 0;
  int            m_cnt = 0;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            cur_delay;
  logic [DW-1:0] cur_rdata;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 0;
      mem_ack  = 1'b0;
    end else if (mem_en) begin
      if (!m_active) begin
        m_active = 1;
        m_cnt    = 0;
        if (mq_delay.size() == 0) begin
          check("mem_unexpected_access", 32'd1, 32'd0);
          cur_we = mem_we; cur_addr = mem_addr; cur_wdata = mem_wdata;
          cur_delay = 0; cur_rdata = '0;
        end else begin
          cur_we    = mq_we.pop_front();
          cur_addr  = mq_addr.pop_front();
          cur_wdata = mq_wdata.pop_front();
          cur_delay = mq_delay.pop_front();
          cur_rdata = mq_rdata.pop_front();
        end
      end
      check("mem_we", 32'(mem_we), 32'(cur_we));
      check("mem_addr", 32'(mem_addr), 32'(cur_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
      mem_ack   = (m_cnt == cur_delay);
      mem_rdata = mem_ack ? cur_rdata : DW'($urandom);
      m_cnt++;
    end else begin
      // Noise outside an access must be ignored.
      m_active  = 0;
      mem_ack   = 1'($urandom);
      mem_rdata = DW'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      check("ready_only_when_idle", 32'(req_ready), 32'(!(mem_en || rsp_valid)));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          logic [DW:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(ec));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e[DW-1:0]));
          check("rsp_err", 32'(rsp_err), 32'(e[DW]));
          last_rdata = e[DW-1:0];
          last_err   = e[DW];
        end
      end else begin
        check("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
        check("rsp_err_hold", 32'(rsp_err), 32'(last_err));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    int r;
    int dly;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: zero-wait read, 3-wait write, timeout then recovery, ack on the timeout cycle.
    issue(1'b0, 16'h1234, 8'h00, 0, 8'hA5, 1);
    repeat (3) @(negedge clk);
    issue(1'b1, 16'hFFFE, 8'h3C, 3, 8'h77, 1);
    repeat (6) @(negedge clk);
    issue(1'b0, 16'h0042, 8'h00, MAX_WAIT + 5, 8'h11, 1);
    issue(1'b0, 16'h0043, 8'h00, 1, 8'h5A, 1);
    issue(1'b0, 16'h00F0, 8'h00, MAX_WAIT - 1, 8'hC3, 1);

    // Random traffic, including back-to-back with req_valid held.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      dly = (r < 7) ? $urandom_range(0, 4) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 3);
      issue(1'($urandom), AW'($urandom), DW'($urandom), dly, DW'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the second ACCESS cycle aborts without a response.
    issue(1'b0, 16'hBEEF, 8'h00, 50, 8'h99, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid_after", 32'(rsp_valid), 32'd0);
    mq_we.delete(); mq_addr.delete(); mq_wdata.delete(); mq_delay.delete(); mq_rdata.delete();

    issue(1'b0, 16'h2000, 8'h00, 2, 8'h6E, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, address width of core request and memory port.
REQ-002 Parameter: DATA_WIDTH, 8, data width.
REQ-003 Parameter: MAX_WAIT, 15, maximum wait cycles before timeout (1..255).
REQ-004 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req_valid  input  1  core requests an access.
REQ-007 Port: req_write  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  ADDR_WIDTH  access address.
REQ-009 Port: req_wdata  input  DATA_WIDTH  write data.
REQ-010 Port: req_ready  output  1  controller accepts a request this cycle.
REQ-011 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-012 Port: rsp_rdata  output  DATA_WIDTH  read data; meaningful only with rsp_valid.
REQ-013 Port: rsp_err  output  1  access timed out; qualified by rsp_valid.
REQ-014 Port: mem_en  output  1  memory access strobe.
REQ-015 Port: mem_we  output  1  memory write enable; only meaningful with mem_en.
REQ-016 Port: mem_addr  output  ADDR_WIDTH  registered access address.
REQ-017 Port: mem_wdata  output  DATA_WIDTH  registered write data.
REQ-018 Port: mem_rdata  input  DATA_WIDTH  memory read data, sampled with mem_ack.
REQ-019 Port: mem_ack  input  1  memory completes the access this cycle.

Function
REQ-020 States: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE with req_valid=1: capture req_write/addr/wdata, clear wait counter, go to ACCESS; otherwise stay in IDLE.
REQ-022 ACCESS: mem_en=1; mem_we, mem_addr and mem_wdata SHALL be driven from the captured registers and held stable until leaving ACCESS.
REQ-023 ACCESS with mem_ack=1: capture mem_rdata on reads (0 on writes) into rsp_rdata, rsp_err=0, go to RESP.
REQ-024 ACCESS with mem_ack=0: increment the wait counter; when the counter equals MAX_WAIT, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 Simultaneous mem_ack and timeout: ack wins, rsp_err=0.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, then unconditionally go to IDLE; no backpressure.
REQ-027 Latency: with accept at edge N and mem_ack high in the first ACCESS cycle, rsp_valid is high in cycle N+2; the next request is accepted in cycle N+3 at the earliest.
REQ-028 mem_ack outside ACCESS SHALL be ignored; req_valid outside IDLE SHALL be ignored and not captured.
REQ-029 rsp_rdata and rsp_err SHALL hold their last values outside RESP.
REQ-030 Wait counter SHALL be ceil(log2(MAX_WAIT+1)) bits wide and SHALL NOT wrap.

Reset
REQ-031 reset high at a posedge: state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-032 reset during ACCESS or RESP SHALL abort the access with no rsp_valid pulse; req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-033 The state enum type mbc_state_t SHALL live in the shared package hmc6502_pkg; MAX_WAIT stays a module parameter.
REQ-034 Wait counting SHALL be a sub-module wait_counter, with clear, enable and terminal-count outputs.
REQ-035 All outputs SHALL be registered; there SHALL be no latches and no tristates.

Verification
REQ-036 Read, zero wait: accept addr=16'h1234, mem_ack with mem_rdata=8'hA5 in the first ACCESS cycle -> rsp_valid at N+2, rsp_rdata=8'hA5, rsp_err=0.
REQ-037 Write, 3 waits: addr=16'hFFFE, wdata=8'h3C, mem_ack after 3 low cycles -> mem_we=1 with addr/data stable for 4 cycles, rsp_valid at N+5, rsp_rdata=0.
REQ-038 Timeout: MAX_WAIT=15, mem_ack never asserted -> rsp_valid with rsp_err=1 after 15 ACCESS cycles; a second request is then accepted normally.
REQ-039 Ack and timeout in the same cycle -> rsp_err=0 and rsp_rdata equals mem_rdata.
REQ-040 Reset in the 2nd ACCESS cycle -> mem_en=0 next cycle, no rsp_valid pulse, req_ready=1 after reset release.
REQ-041 Back-to-back requests with req_valid held high -> exactly one acceptance per transaction, and req_ready stays low in ACCESS and RESP.
